// File: rtl/sd_bus_scheduler.sv
// Shares the single SPI link to the SD card between several client FSMs:
// priority/round-robin grant, start pulse, busy tracking with watchdog, idle gap.
module sd_bus_scheduler #(
  parameter int N_REQ      = 3,
  parameter int GAP_CYCLES = 8,
  parameter int START_WIN  = 4,
  parameter int TIMEOUT_W  = 20
) (
  input  logic             i_s_clk,
  input  logic             i_reset_n,
  input  logic [N_REQ-1:0] i_req,
  input  logic [N_REQ-1:0] i_busy,
  input  logic [N_REQ-1:0] i_mosi,
  output logic [N_REQ-1:0] o_start,
  output logic [N_REQ-1:0] o_grant,
  output logic             MOSI,
  output logic             o_cs_n,
  output logic             o_timeout,
  output logic             o_err,
  output logic [7:0]       o_8_LED
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [TIMEOUT_W-1:0] WD_ONES = '1;
  localparam logic [TIMEOUT_W-1:0] WD_LAST = WD_ONES - TIMEOUT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_ACTIVE    = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  state_t               state, state_nx;
  logic [IW-1:0]        rr_ptr, rr_ptr_nx;
  logic [IW-1:0]        gidx, gidx_nx;
  logic [IW-1:0]        win_idx, cand;
  logic                 win_valid;
  logic [N_REQ-1:0]     win_onehot, grant_nx, start_nx;
  logic                 cs_n_nx, timeout_nx, err_nx;
  logic [3:0]           win_cnt, win_cnt_nx;
  logic [7:0]           gap_cnt, gap_cnt_nx;
  logic [TIMEOUT_W-1:0] wd_cnt, wd_cnt_nx;
  logic                 busy_g;
  logic [N_REQ+3:0]     grant_ext;

  // Client 0 always wins; otherwise the search starts after the last
  // round-robin winner. Scanning downwards lets the nearest candidate win.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    if (i_req[0]) begin
      win_valid = 1'b1;
    end else begin
      for (int off = N_REQ - 1; off >= 1; off--) begin
        cand = IW'(((int'(rr_ptr) - 1 + off) % (N_REQ - 1)) + 1);
        if (i_req[cand]) begin
          win_valid = 1'b1;
          win_idx   = cand;
        end
      end
    end
  end

  always_comb begin
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
  end

  assign busy_g    = i_busy[gidx];
  assign MOSI      = (|o_grant) ? i_mosi[gidx] : 1'b1;
  assign grant_ext = {4'b0000, o_grant};
  assign o_8_LED   = {state, o_err, grant_ext[3:0]};

  always_ff @(posedge i_s_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= S_IDLE;
      rr_ptr    <= IW'(N_REQ - 1);
      gidx      <= '0;
      o_grant   <= '0;
      o_start   <= '0;
      o_cs_n    <= 1'b1;
      o_timeout <= 1'b0;
      o_err     <= 1'b0;
      win_cnt   <= '0;
      gap_cnt   <= '0;
      wd_cnt    <= '0;
    end else begin
      state     <= state_nx;
      rr_ptr    <= rr_ptr_nx;
      gidx      <= gidx_nx;
      o_grant   <= grant_nx;
      o_start   <= start_nx;
      o_cs_n    <= cs_n_nx;
      o_timeout <= timeout_nx;
      o_err     <= err_nx;
      win_cnt   <= win_cnt_nx;
      gap_cnt   <= gap_cnt_nx;
      wd_cnt    <= wd_cnt_nx;
    end
  end

  // Busy falling wins over a watchdog expiry in the same cycle.
  always_comb begin
    state_nx   = state;
    rr_ptr_nx  = rr_ptr;
    gidx_nx    = gidx;
    grant_nx   = o_grant;
    start_nx   = '0;
    cs_n_nx    = o_cs_n;
    timeout_nx = 1'b0;
    err_nx     = o_err;
    win_cnt_nx = win_cnt;
    gap_cnt_nx = gap_cnt;
    wd_cnt_nx  = wd_cnt;
    case (state)
      S_IDLE: begin
        if (win_valid) begin
          state_nx = S_START;
          grant_nx = win_onehot;
          start_nx = win_onehot;
          cs_n_nx  = 1'b0;
          gidx_nx  = win_idx;
          if (!i_req[0]) rr_ptr_nx = win_idx;
        end
      end
      S_START: begin
        state_nx   = S_WAIT_BUSY;
        win_cnt_nx = '0;
      end
      S_WAIT_BUSY: begin
        if (busy_g) begin
          state_nx  = S_ACTIVE;
          wd_cnt_nx = '0;
        end else if (win_cnt == 4'(START_WIN - 1)) begin
          state_nx   = S_GAP;
          grant_nx   = '0;
          cs_n_nx    = 1'b1;
          gap_cnt_nx = '0;
        end else begin
          win_cnt_nx = win_cnt + 4'd1;
        end
      end
      S_ACTIVE: begin
        if (!busy_g || wd_cnt == WD_LAST) begin
          state_nx   = S_GAP;
          grant_nx   = '0;
          cs_n_nx    = 1'b1;
          gap_cnt_nx = '0;
          if (busy_g) begin
            timeout_nx = 1'b1;
            err_nx     = 1'b1;
          end
        end else begin
          wd_cnt_nx = wd_cnt + TIMEOUT_W'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt == 8'(GAP_CYCLES - 1)) begin
          state_nx = S_IDLE;
        end else begin
          gap_cnt_nx = gap_cnt + 8'd1;
        end
      end
      default: begin
        state_nx = S_IDLE;
        grant_nx = '0;
        cs_n_nx  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_sd_bus_scheduler.sv
// Self-checking bench for sd_bus_scheduler: acts as the three clients and
// predicts grant order and CS timing from a queue-based arbitration model.
module tb_sd_bus_scheduler;

  localparam int N      = 3;
  localparam int GAP    = 8;
  localparam int SW     = 4;
  localparam int TW     = 5;
  localparam int WD_LIM = (1 << TW) - 1;
  localparam int M_NOBUSY = 0;
  localparam int M_NORMAL = 1;
  localparam int M_STUCK  = 2;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] req   = '0;
  logic [N-1:0] busy  = '0;
  logic [N-1:0] mosi  = '1;
  logic [N-1:0] o_start, o_grant;
  logic         MOSI, o_cs_n, o_timeout, o_err;
  logic [7:0]   o_8_LED;

  int vectors = 0;
  int errors  = 0;
  int rr_q[$];

  sd_bus_scheduler #(
    .N_REQ(N), .GAP_CYCLES(GAP), .START_WIN(SW), .TIMEOUT_W(TW)
  ) dut (
    .i_s_clk(clk), .i_reset_n(rst_n),
    .i_req(req), .i_busy(busy), .i_mosi(mosi),
    .o_start(o_start), .o_grant(o_grant), .MOSI(MOSI),
    .o_cs_n(o_cs_n), .o_timeout(o_timeout), .o_err(o_err),
    .o_8_LED(o_8_LED)
  );

  always #5 clk = ~clk;

  // Round-robin order kept as a queue: the winner moves to the back.
  function automatic int predict(input logic [N-1:0] r);
    int w;
    w = -1;
    if (r[0]) return 0;
    for (int i = 0; i < rr_q.size(); i++) begin
      if (r[rr_q[i]]) begin
        w = rr_q[i];
        for (int j = 0; j <= i; j++) rr_q.push_back(rr_q.pop_front());
        break;
      end
    end
    return w;
  endfunction

  task automatic wait_start(input int budget, output int n, output bit found);
    n = 0;
    found = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (o_start != '0) begin
        found = 1'b1;
        break;
      end
      n++;
      vectors++;
      if (o_cs_n !== 1'b1 || o_grant !== 3'b000 || MOSI !== 1'b1 || o_timeout !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_gap: cs_n=%b grant=%b mosi=%b timeout=%b, want 1 000 1 0",
                 o_cs_n, o_grant, MOSI, o_timeout);
      end
    end
  endtask

  // Called at the negedge where o_start is visible; ends at the negedge where CS rises.
  task automatic do_txn(input int mode, input int d, input int len, input logic [N-1:0] req_next);
    int w, exp_low, low, l_eff;
    logic [N-1:0] oh;
    bit exp_to;
    w  = predict(req);
    oh = 3'(1 << w);
    vectors++;
    if (o_start !== oh || o_grant !== oh || o_cs_n !== 1'b0 || o_8_LED[3:0] !== {1'b0, oh}) begin
      errors++;
      $display("[TB] FAIL start_grant: start=%b grant=%b cs_n=%b led=%b, want %b %b 0 led[3:0]=0%b",
               o_start, o_grant, o_cs_n, o_8_LED, oh, oh, oh);
    end
    req = req_next;
    l_eff = len;
    exp_to = 1'b0;
    case (mode)
      M_NOBUSY: begin exp_low = SW; l_eff = 0; end
      M_NORMAL: exp_low = d + len + 1;
      default: begin exp_low = d + WD_LIM + 1; exp_to = 1'b1; l_eff = 100000; end
    endcase
    low = 0;
    for (int k = 1; k <= exp_low + 10; k++) begin
      @(negedge clk);
      if (o_cs_n) break;
      low++;
      vectors++;
      if (o_grant !== oh || o_start !== 3'b000 || o_timeout !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold_grant: grant=%b start=%b timeout=%b, want %b 000 0",
                 o_grant, o_start, o_timeout, oh);
      end
      busy = 3'($urandom) & ~oh;
      if (k - 1 >= d && k - 1 < d + l_eff) busy[w] = 1'b1;
      mosi = 3'($urandom);
      #1;
      vectors++;
      if (MOSI !== mosi[w]) begin
        errors++;
        $display("[TB] FAIL mosi_track: MOSI=%b, want %b", MOSI, mosi[w]);
      end
    end
    busy = '0;
    vectors++;
    if (low !== exp_low) begin
      errors++;
      $display("[TB] FAIL cs_low_len: got %0d cycles, want %0d", low, exp_low);
    end
    vectors++;
    if (o_timeout !== exp_to || o_grant !== 3'b000 || MOSI !== 1'b1) begin
      errors++;
      $display("[TB] FAIL txn_end: timeout=%b grant=%b mosi=%b, want %b 000 1",
               o_timeout, o_grant, MOSI, exp_to);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (o_grant !== 3'b000 || o_start !== 3'b000 || o_cs_n !== 1'b1 || MOSI !== 1'b1 ||
        o_timeout !== 1'b0 || o_err !== 1'b0 || o_8_LED !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_vals: grant=%b start=%b cs_n=%b mosi=%b to=%b err=%b led=%h",
               o_grant, o_start, o_cs_n, MOSI, o_timeout, o_err, o_8_LED);
    end
    rst_n = 1'b1;
    rr_q = {1, 2};
    @(negedge clk);
    vectors++;
    if (o_grant !== 3'b000 || o_cs_n !== 1'b1 || o_8_LED !== 8'h00) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: grant=%b cs_n=%b led=%h, want 000 1 00",
               o_grant, o_cs_n, o_8_LED);
    end
  endtask

  task automatic test_single;
    int n;
    bit f;
    req = 3'b010;
    wait_start(30, n, f);
    if (!f) begin
      errors++;
      $display("[TB] FAIL single_start: no start seen, want 010");
    end else begin
      do_txn(M_NORMAL, int'($urandom_range(SW - 1, 0)), 20, 3'b000);
    end
    // A request withdrawn during the gap must never be granted.
    req = 3'b100;
    @(negedge clk);
    req = 3'b000;
    wait_start(25, n, f);
    vectors++;
    if (f) begin
      errors++;
      $display("[TB] FAIL dropped_req: start=%b, want no start", o_start);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    bit f;
    req = 3'b110;
    for (int i = 0; i < 6; i++) begin
      wait_start(40, n, f);
      if (!f) begin
        errors++;
        $display("[TB] FAIL b2b_start: no start in txn %0d", i);
        break;
      end
      if (i > 0) begin
        vectors++;
        if (n !== GAP) begin
          errors++;
          $display("[TB] FAIL b2b_gap: got %0d idle cycles, want %0d", n, GAP);
        end
      end
      do_txn(M_NORMAL, int'($urandom_range(SW - 1, 0)), int'($urandom_range(25, 1)), 3'b110);
    end
    req = 3'b000;
  endtask

  task automatic test_priority;
    int n;
    bit f;
    logic [N-1:0] nexts[5];
    nexts = '{3'b110, 3'b110, 3'b111, 3'b110, 3'b000};
    req = 3'b111;
    for (int i = 0; i < 5; i++) begin
      wait_start(40, n, f);
      if (!f) begin
        errors++;
        $display("[TB] FAIL prio_start: no start in txn %0d", i);
        break;
      end
      do_txn(M_NORMAL, int'($urandom_range(SW - 1, 0)), int'($urandom_range(12, 1)), nexts[i]);
    end
    req = 3'b000;
  endtask

  task automatic test_no_busy;
    int n;
    bit f;
    req = 3'b100;
    wait_start(40, n, f);
    if (!f) begin
      errors++;
      $display("[TB] FAIL nobusy_start: no start seen");
    end else begin
      do_txn(M_NOBUSY, 0, 0, 3'b000);
    end
    vectors++;
    if (o_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL nobusy_err: err=%b, want 0", o_err);
    end
  endtask

  task automatic test_timeout;
    int n;
    bit f;
    req = 3'b010;
    wait_start(40, n, f);
    if (!f) begin
      errors++;
      $display("[TB] FAIL wd_edge_start: no start seen");
    end else begin
      do_txn(M_NORMAL, 1, WD_LIM, 3'b010);
    end
    vectors++;
    if (o_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wd_edge_err: err=%b, want 0", o_err);
    end
    wait_start(40, n, f);
    if (!f) begin
      errors++;
      $display("[TB] FAIL wd_stuck_start: no start seen");
    end else begin
      do_txn(M_STUCK, int'($urandom_range(SW - 1, 0)), 0, 3'b000);
    end
    vectors++;
    if (o_err !== 1'b1 || o_8_LED[4] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wd_err_set: err=%b led[4]=%b, want 1 1", o_err, o_8_LED[4]);
    end
    req = 3'b100;
    wait_start(40, n, f);
    if (!f) begin
      errors++;
      $display("[TB] FAIL wd_after_start: no start seen");
    end else begin
      do_txn(M_NORMAL, 0, 6, 3'b000);
    end
    vectors++;
    if (o_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wd_err_sticky: err=%b, want 1", o_err);
    end
  endtask

  task automatic test_random;
    int n;
    bit f;
    req = 3'($urandom_range(7, 1));
    for (int i = 0; i < 15; i++) begin
      wait_start(40, n, f);
      if (!f) begin
        errors++;
        $display("[TB] FAIL rand_start: no start in txn %0d", i);
        break;
      end
      if (i > 0) begin
        vectors++;
        if (n !== GAP) begin
          errors++;
          $display("[TB] FAIL rand_gap: got %0d idle cycles, want %0d", n, GAP);
        end
      end
      do_txn(int'($urandom_range(M_NORMAL, M_NOBUSY)), int'($urandom_range(SW - 1, 0)),
             int'($urandom_range(WD_LIM, 1)), 3'($urandom_range(7, 1)));
    end
    req = 3'b000;
    wait_start(40, n, f);
    if (f) do_txn(M_NOBUSY, 0, 0, 3'b000);
  endtask

  task automatic test_reset_mid;
    int n;
    bit f;
    req = 3'b010;
    wait_start(40, n, f);
    vectors++;
    if (!f || o_grant !== 3'b010) begin
      errors++;
      $display("[TB] FAIL rst_mid_grant: found=%0d grant=%b, want 1 010", f, o_grant);
    end
    req = 3'b000;
    @(negedge clk);
    busy = 3'b010;
    repeat (6) begin
      @(negedge clk);
      mosi = 3'($urandom);
    end
    mosi = 3'b000;
    #1;
    vectors++;
    if (o_cs_n !== 1'b0 || MOSI !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid_active: cs_n=%b mosi=%b, want 0 0", o_cs_n, MOSI);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (o_cs_n !== 1'b1 || o_grant !== 3'b000 || MOSI !== 1'b1 || o_start !== 3'b000 ||
        o_err !== 1'b0 || o_timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid_async: cs_n=%b grant=%b mosi=%b start=%b err=%b to=%b",
               o_cs_n, o_grant, MOSI, o_start, o_err, o_timeout);
    end
    busy = '0;
    rr_q = {1, 2};
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req = 3'b110;
    wait_start(40, n, f);
    if (!f) begin
      errors++;
      $display("[TB] FAIL rst_mid_regrant: no start after reset");
    end else begin
      do_txn(M_NORMAL, 0, 5, 3'b000);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_priority();
    test_no_busy();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
